alu_control: RTL and testbench
==============================

ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter REG_OUT, default 1: 1 = registered outputs with one-cycle latency; 0 = combinational decode outputs, with valid passed straight through.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 Port in_valid, input, 1 bit: ins/ALUOp are meaningful this cycle.
REQ-005 Port ins, input, 6 bits: instruction funct field.
REQ-006 Port ALUOp, input, 2 bits: operation class from main control.
REQ-007 Port ALUctrl, output, 2 bits: ALU operation select.
REQ-008 Port out_valid, output, 1 bit: ALUctrl/illegal are meaningful.
REQ-009 Port illegal, output, 1 bit: current decode was not a supported operation.
REQ-010 Port illegal_cnt, output, 8 bits: illegal-decode counter; present only when ALU_CONTROL_ILLEGAL_CNT_EN is defined.

Function
REQ-011 ALUctrl encodings SHALL be ADD=2'b00, SUB=2'b01, SLT=2'b10, NOP=2'b11.
REQ-012 ALUOp=2'b00 (load/store) SHALL yield ADD regardless of ins; illegal=0.
REQ-013 ALUOp=2'b01 (branch) SHALL yield SUB regardless of ins; illegal=0.
REQ-014 ALUOp=2'b10 (R-type) SHALL decode ins as follows:
- 6'b100000 -> ADD
- 6'b100010 -> SUB
- 6'b101010 -> SLT
- any other value -> NOP with illegal=1.
REQ-015 ALUOp=2'b11 SHALL yield NOP with illegal=1 regardless of ins.
REQ-016 With REG_OUT=1, decode of a cycle's inputs SHALL appear on ALUctrl/illegal at the next rising edge; out_valid SHALL equal in_valid delayed one cycle.
REQ-017 With REG_OUT=1, when in_valid=0 at an edge, ALUctrl and illegal SHALL hold their previous values and out_valid SHALL go 0.
REQ-018 With REG_OUT=0, ALUctrl/illegal SHALL follow the inputs combinationally and out_valid SHALL equal in_valid.
REQ-019 The output decode SHALL be fully specified for all 256 input combinations; no X output for known inputs.

Reset
REQ-020 While rst_n=0 at a rising edge: ALUctrl SHALL become 2'b00, illegal 0, out_valid 0, illegal_cnt 0.
REQ-021 Inputs presented in the reset cycle SHALL be discarded; decoding resumes on the first edge with rst_n=1.

Configuration
REQ-022 When ALU_CONTROL_ILLEGAL_CNT_EN is defined, illegal_cnt SHALL increment by 1 on each edge with in_valid=1 and an illegal decode.
REQ-023 The counter SHALL saturate at 8'hFF.
REQ-024 The counter SHALL be independent of REG_OUT: it counts at the input edge.
REQ-025 When ALU_CONTROL_ILLEGAL_CNT_EN is not defined, the illegal_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 Shared package alu_pkg SHALL hold:
- the ALUOp class constants (LDST=00, BRANCH=01, RTYPE=10, RSVD=11)
- the ALUctrl encodings
- the funct constants (FUNCT_ADD=6'h20, FUNCT_SUB=6'h22, FUNCT_SLT=6'h2A).
REQ-027 The combinational funct decode SHALL be a sub-module alu_funct_decode (ins in; ALUctrl and illegal out), instantiated once by alu_control.

Verification
REQ-028 ALUOp=11, ins=111111, in_valid=1 -> next cycle ALUctrl=11, illegal=1, out_valid=1; illegal_cnt +1 when enabled.
REQ-029 ALUOp=00 then 01, each with ins=111111 -> ALUctrl=00 then 01, illegal=0, one cycle later each.
REQ-030 ALUOp=10 with ins=100000, 100010, 101010 on consecutive cycles -> ALUctrl=00, 01, 10 on the following cycles, illegal=0.
REQ-031 ALUOp=10 with ins=000000 -> ALUctrl=11, illegal=1.
REQ-032 Assert rst_n=0 mid-stream with valid inputs -> next edge all outputs 0; deassert, apply ALUOp=01 -> ALUctrl=01 one cycle later.
REQ-033 With the macro defined, drive 300 consecutive illegal valid decodes -> illegal_cnt=8'hFF and holds; in_valid=0 illegal inputs do not count.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU control slice: ALUOp classes,
//                ALUctrl encodings and R-type funct codes.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef logic [1:0] aluop_t;
  typedef logic [1:0] aluctrl_t;
  typedef logic [5:0] funct_t;

  // Operation class coming from the main control unit
  localparam aluop_t ALUOP_LDST   = 2'b00;
  localparam aluop_t ALUOP_BRANCH = 2'b01;
  localparam aluop_t ALUOP_RTYPE  = 2'b10;
  localparam aluop_t ALUOP_RSVD   = 2'b11;

  // ALU operation select driven to the datapath
  localparam aluctrl_t ALUCTRL_ADD = 2'b00;
  localparam aluctrl_t ALUCTRL_SUB = 2'b01;
  localparam aluctrl_t ALUCTRL_SLT = 2'b10;
  localparam aluctrl_t ALUCTRL_NOP = 2'b11;

  // Supported R-type funct codes
  localparam funct_t FUNCT_ADD = 6'h20;
  localparam funct_t FUNCT_SUB = 6'h22;
  localparam funct_t FUNCT_SLT = 6'h2A;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_funct_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_funct_decode
//  Description : Combinational R-type funct decode. Unsupported funct codes
//                map to NOP and raise illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] ins,
  output logic [1:0] ALUctrl,
  output logic       illegal
);

  // Map funct to ALU operation; anything not listed is illegal
  always_comb begin
    ALUctrl = ALUCTRL_NOP;
    illegal = 1'b1;
    case (ins)
      FUNCT_ADD: begin ALUctrl = ALUCTRL_ADD; illegal = 1'b0; end
      FUNCT_SUB: begin ALUctrl = ALUCTRL_SUB; illegal = 1'b0; end
      FUNCT_SLT: begin ALUctrl = ALUCTRL_SLT; illegal = 1'b0; end
      default:   ;
    endcase
  end

endmodule : alu_funct_decode
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control
//  Description : ALU control decode. Combines the ALUOp class with the R-type
//                funct decode; outputs are either registered (REG_OUT=1,
//                one-cycle latency, hold when not valid) or combinational.
//                Optional saturating illegal-decode counter is built when
//                ALU_CONTROL_ILLEGAL_CNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control
  import alu_pkg::*;
#(
  parameter int unsigned REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] ins,
  input  logic [1:0] ALUOp,
  output logic [1:0] ALUctrl,
  output logic       out_valid,
`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
  output logic [7:0] illegal_cnt,
`endif
  output logic       illegal
);

  logic [1:0] w_fn_ctrl;
  logic       w_fn_illegal;
  logic [1:0] w_ctrl;
  logic       w_illegal;

  alu_funct_decode u_funct_decode (
    .ins     (ins),
    .ALUctrl (w_fn_ctrl),
    .illegal (w_fn_illegal)
  );

  // Select the operation by class; only R-type consults the funct field
  always_comb begin
    w_ctrl    = ALUCTRL_NOP;
    w_illegal = 1'b1;
    case (ALUOp)
      ALUOP_LDST:   begin w_ctrl = ALUCTRL_ADD; w_illegal = 1'b0; end
      ALUOP_BRANCH: begin w_ctrl = ALUCTRL_SUB; w_illegal = 1'b0; end
      ALUOP_RTYPE:  begin w_ctrl = w_fn_ctrl;   w_illegal = w_fn_illegal; end
      ALUOP_RSVD:   begin w_ctrl = ALUCTRL_NOP; w_illegal = 1'b1; end
      default:      ;
    endcase
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      // Register the decode; hold ALUctrl/illegal across invalid cycles
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ALUctrl   <= ALUCTRL_ADD;
          illegal   <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            ALUctrl <= w_ctrl;
            illegal <= w_illegal;
          end
        end
      end
    end else begin : g_comb_out
      // Clock and reset only matter to the optional counter in this build
      logic w_unused_comb;
      assign w_unused_comb = &{1'b0, clk, rst_n};
      assign ALUctrl   = w_ctrl;
      assign illegal   = w_illegal;
      assign out_valid = in_valid;
    end
  endgenerate

`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
  logic [7:0] r_illegal_cnt;

  // Count valid illegal decodes at the input edge, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal_cnt <= 8'h00;
    end else if (in_valid && w_illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'h01;
    end
  end

  assign illegal_cnt = r_illegal_cnt;
`endif

endmodule : alu_control
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control
//  Description : Directed bench for alu_control. Drives a registered
//                instance and a combinational instance with the same inputs
//                and checks both against hand-computed decode values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] ins;
  logic [1:0] ALUOp;

  logic [1:0] r_ctrl,  c_ctrl;
  logic       r_valid, c_valid;
  logic       r_ill,   c_ill;
`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
  logic [7:0] r_cnt, c_cnt;
`endif

  int vectors = 0;
  int fails   = 0;

  // Bench-side expectations for the registered instance
  logic [1:0] exp_ctrl;
  logic       exp_ill;
  logic       exp_valid;
  int         exp_cnt;

  alu_control #(.REG_OUT(1)) u_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .ins         (ins),
    .ALUOp       (ALUOp),
    .ALUctrl     (r_ctrl),
    .out_valid   (r_valid),
`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
    .illegal_cnt (r_cnt),
`endif
    .illegal     (r_ill)
  );

  alu_control #(.REG_OUT(0)) u_comb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .ins         (ins),
    .ALUOp       (ALUOp),
    .ALUctrl     (c_ctrl),
    .out_valid   (c_valid),
`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
    .illegal_cnt (c_cnt),
`endif
    .illegal     (c_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Apply one input set: check the combinational instance before the edge,
  // then the registered instance just after it. dctrl/dill is the
  // hand-computed decode of (op, fn).
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [1:0] dctrl, input logic dill, input string tag);
    in_valid = v;
    ALUOp    = op;
    ins      = fn;
    #1;
    check({tag, "/comb_ctrl"},  {6'd0, c_ctrl},  {6'd0, dctrl});
    check({tag, "/comb_ill"},   {7'd0, c_ill},   {7'd0, dill});
    check({tag, "/comb_valid"}, {7'd0, c_valid}, {7'd0, v});
    if (!rst_n) begin
      exp_ctrl = 2'b00; exp_ill = 1'b0; exp_valid = 1'b0; exp_cnt = 0;
    end else begin
      exp_valid = v;
      if (v) begin exp_ctrl = dctrl; exp_ill = dill; end
      if (v && dill && exp_cnt != 255) exp_cnt++;
    end
    @(posedge clk);
    #1;
    check({tag, "/reg_ctrl"},  {6'd0, r_ctrl},  {6'd0, exp_ctrl});
    check({tag, "/reg_ill"},   {7'd0, r_ill},   {7'd0, exp_ill});
    check({tag, "/reg_valid"}, {7'd0, r_valid}, {7'd0, exp_valid});
`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
    check({tag, "/reg_cnt"},  r_cnt, 8'(exp_cnt));
    check({tag, "/comb_cnt"}, c_cnt, 8'(exp_cnt));
`endif
    #3;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ins      = 6'h00;
    ALUOp    = 2'b00;
    exp_ctrl = 2'b00; exp_ill = 1'b0; exp_valid = 1'b0; exp_cnt = 0;

    // Reset with valid illegal inputs present: they must be discarded
    step(1'b1, 2'b11, 6'h3F, 2'b11, 1'b1, "rst0");
    step(1'b1, 2'b11, 6'h3F, 2'b11, 1'b1, "rst1");
    rst_n = 1'b1;

    // Reserved class, then load/store and branch with a junk funct
    step(1'b1, 2'b11, 6'h3F, 2'b11, 1'b1, "rsvd");
    step(1'b1, 2'b00, 6'h3F, 2'b00, 1'b0, "ldst");
    step(1'b1, 2'b01, 6'h3F, 2'b01, 1'b0, "branch");

    // R-type supported functs back to back
    step(1'b1, 2'b10, 6'b100000, 2'b00, 1'b0, "r_add");
    step(1'b1, 2'b10, 6'b100010, 2'b01, 1'b0, "r_sub");
    step(1'b1, 2'b10, 6'b101010, 2'b10, 1'b0, "r_slt");

    // R-type unsupported functs, including near misses of supported codes
    step(1'b1, 2'b10, 6'b000000, 2'b11, 1'b1, "r_zero");
    step(1'b1, 2'b10, 6'b101011, 2'b11, 1'b1, "r_slt_p1");
    step(1'b1, 2'b10, 6'b000010, 2'b11, 1'b1, "r_sub_b5");

    // Invalid cycle: registered outputs hold, valid drops
    step(1'b1, 2'b10, 6'b101010, 2'b10, 1'b0, "pre_hold");
    step(1'b0, 2'b11, 6'h00, 2'b11, 1'b1, "hold");
    step(1'b0, 2'b00, 6'h15, 2'b00, 1'b0, "hold2");

    // Mid-stream reset with valid inputs, then resume with a branch
    rst_n = 1'b0;
    step(1'b1, 2'b10, 6'b100010, 2'b01, 1'b0, "mid_rst");
    rst_n = 1'b1;
    step(1'b1, 2'b01, 6'h00, 2'b01, 1'b0, "resume");

`ifdef ALU_CONTROL_ILLEGAL_CNT_EN
    // Invalid illegal inputs never count; valid ones do, up to saturation
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 6'h3F, 2'b11, 1'b1, "cnt_inv");
    for (int i = 0; i < 300; i++) step(1'b1, 2'b11, 6'h3F, 2'b11, 1'b1, "cnt_sat");
    check("cnt_final_reg", r_cnt, 8'hFF);
    step(1'b1, 2'b10, 6'h01, 2'b11, 1'b1, "cnt_hold");
    step(1'b0, 2'b11, 6'h3F, 2'b11, 1'b1, "cnt_hold_inv");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_alu_control
`default_nettype wire
